// File: rtl/ctrl_input_cond.sv
// Input conditioning for asynchronous control pins: per-channel synchroniser,
// glitch-rejecting debounce, one-cycle edge pulses and a long-press hold flag.
module ctrl_input_cond #(
  parameter int                NUM_CH          = 4,
  parameter int                SYNC_STAGES     = 2,
  parameter int                DEBOUNCE_CYCLES = 270000,
  parameter int                HOLD_CYCLES     = 27000000,
  parameter logic [NUM_CH-1:0] RESET_VAL       = {NUM_CH{1'b0}},
  parameter logic [NUM_CH-1:0] DEB_EN          = {NUM_CH{1'b1}}
) (
  input  logic              clk27,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] din,
  output logic [NUM_CH-1:0] dout,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] hold,
  output logic              any_edge
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0][DW-1:0]          deb_cnt_q, deb_cnt_d;
  logic [NUM_CH-1:0][HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic [NUM_CH-1:0]                  dout_q, dout_d;
  logic [NUM_CH-1:0]                  rise_q, rise_d;
  logic [NUM_CH-1:0]                  fall_q, fall_d;
  logic [NUM_CH-1:0]                  hold_q, hold_d;
  logic                               any_edge_q, any_edge_d;
  logic [NUM_CH-1:0]                  s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], din};
    dout_d     = dout_q;
    deb_cnt_d  = '0;
    hold_cnt_d = '0;
    hold_d     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // A single cycle of agreement leaves the counter at zero, so a new
      // level needs an unbroken run of mismatches to be accepted.
      if (!DEB_EN[i]) begin
        dout_d[i] = s[i];
      end else if (s[i] != dout_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          dout_d[i] = s[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end

      if ((HOLD_CYCLES == 0) || !dout_q[i] || !dout_d[i]) begin
        hold_cnt_d[i] = '0;
      end else if (hold_cnt_q[i] != HOLD_MAX) begin
        hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
      end else begin
        hold_cnt_d[i] = hold_cnt_q[i];
      end
      hold_d[i] = (HOLD_CYCLES != 0) && dout_d[i] && (hold_cnt_d[i] == HOLD_MAX);
    end
    rise_d     = dout_d & ~dout_q;
    fall_d     = ~dout_d & dout_q;
    any_edge_d = |(rise_d | fall_d);
  end

  // Reset loads dout with the same level as the synchroniser, so leaving
  // reset can never look like an edge.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= {SYNC_STAGES{RESET_VAL}};
      dout_q     <= RESET_VAL;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      hold_q     <= '0;
      any_edge_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      dout_q     <= dout_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      hold_q     <= hold_d;
      any_edge_q <= any_edge_d;
    end
  end

  assign dout     = dout_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign hold     = hold_q;
  assign any_edge = any_edge_q;

endmodule

// File: tb/tb_ctrl_input_cond.sv
// Directed bench for ctrl_input_cond: expected output values are queued with
// the absolute clock edge they belong to and compared when that edge arrives.
module tb_ctrl_input_cond;

  localparam int SEL_DOUT = 0;
  localparam int SEL_RISE = 1;
  localparam int SEL_FALL = 2;
  localparam int SEL_HOLD = 3;
  localparam int SEL_ANY  = 4;

  logic       clk27;
  logic       reset_n;
  logic [3:0] din;
  logic [3:0] dout;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] hold;
  logic       any_edge;

  typedef struct {
    int         cyc;
    int         sel;
    logic [3:0] mask;
    logic [3:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  ctrl_input_cond #(
    .NUM_CH         (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8),
    .HOLD_CYCLES    (20),
    .RESET_VAL      (4'b0011),
    .DEB_EN         (4'b0111)
  ) dut (
    .clk27   (clk27),
    .reset_n (reset_n),
    .din     (din),
    .dout    (dout),
    .rise    (rise),
    .fall    (fall),
    .hold    (hold),
    .any_edge(any_edge)
  );

  initial clk27 = 1'b0;
  always #5 clk27 = ~clk27;

  always @(posedge clk27) cyc <= cyc + 1;

  function automatic logic [3:0] sel_out(int sel);
    case (sel)
      SEL_DOUT: return dout;
      SEL_RISE: return rise;
      SEL_FALL: return fall;
      SEL_HOLD: return hold;
      default:  return {3'b000, any_edge};
    endcase
  endfunction

  task automatic check(string tag, logic [3:0] obs, logic [3:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s @edge %0d: observed %b expected %b", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic expect_at(int rel, int sel, logic [3:0] mask, logic [3:0] val, string tag);
    exp_t e;
    e.cyc  = cyc + rel;
    e.sel  = sel;
    e.mask = mask;
    e.val  = val;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Outputs held at dout_v with no edge activity for relative edges lo..hi.
  task automatic expect_quiet(int lo, int hi, logic [3:0] dout_v, string tag);
    for (int r = lo; r <= hi; r++) begin
      expect_at(r, SEL_DOUT, 4'b1111, dout_v, {tag, "_dout"});
      expect_at(r, SEL_RISE, 4'b1111, 4'b0000, {tag, "_rise"});
      expect_at(r, SEL_FALL, 4'b1111, 4'b0000, {tag, "_fall"});
      expect_at(r, SEL_ANY,  4'b0001, 4'b0000, {tag, "_any"});
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      int k;
      @(negedge clk27);
      k = 0;
      while (k < sb.size()) begin
        if (sb[k].cyc <= cyc) begin
          check(sb[k].tag, sel_out(sb[k].sel) & sb[k].mask, sb[k].val & sb[k].mask);
          sb.delete(k);
        end else begin
          k++;
        end
      end
    end
  endtask

  initial begin
    logic v;
    int   guard;
    din     = 4'b0000;
    reset_n = 1'b0;
    step(3);

    // Reset state.
    check("rst_dout", dout, 4'b0011);
    check("rst_rise", rise, 4'b0000);
    check("rst_fall", fall, 4'b0000);
    check("rst_hold", hold, 4'b0000);
    check("rst_any",  {3'b000, any_edge}, 4'b0000);

    // Release with inputs matching the reset level: no pulses, hold after 20.
    din     = 4'b0011;
    reset_n = 1'b1;
    expect_quiet(1, 100, 4'b0011, "rel");
    expect_at(19, SEL_HOLD, 4'b1111, 4'b0000, "rel_hold_early");
    expect_at(20, SEL_HOLD, 4'b1111, 4'b0011, "rel_hold_set");
    step(100);

    // Debounced rise on ch2, then hold, then release.
    din[2] = 1'b1;
    expect_quiet(1, 9, 4'b0011, "deb_pre");
    expect_at(10, SEL_DOUT, 4'b1111, 4'b0111, "deb_dout");
    expect_at(10, SEL_RISE, 4'b1111, 4'b0100, "deb_rise");
    expect_at(10, SEL_FALL, 4'b1111, 4'b0000, "deb_fall");
    expect_at(10, SEL_ANY,  4'b0001, 4'b0001, "deb_any");
    expect_at(11, SEL_RISE, 4'b1111, 4'b0000, "deb_rise_end");
    expect_at(11, SEL_ANY,  4'b0001, 4'b0000, "deb_any_end");
    expect_at(11, SEL_DOUT, 4'b1111, 4'b0111, "deb_dout_keep");
    expect_at(29, SEL_HOLD, 4'b1111, 4'b0011, "hold_early");
    expect_at(30, SEL_HOLD, 4'b1111, 4'b0111, "hold_set");
    step(40);
    din[2] = 1'b0;
    expect_at(9,  SEL_DOUT, 4'b1111, 4'b0111, "rel2_dout_pre");
    expect_at(9,  SEL_HOLD, 4'b1111, 4'b0111, "rel2_hold_pre");
    expect_at(9,  SEL_FALL, 4'b1111, 4'b0000, "rel2_fall_pre");
    expect_at(10, SEL_DOUT, 4'b1111, 4'b0011, "rel2_dout");
    expect_at(10, SEL_HOLD, 4'b1111, 4'b0011, "rel2_hold");
    expect_at(10, SEL_FALL, 4'b1111, 4'b0100, "rel2_fall");
    expect_at(10, SEL_RISE, 4'b1111, 4'b0000, "rel2_rise");
    expect_at(10, SEL_ANY,  4'b0001, 4'b0001, "rel2_any");
    expect_at(11, SEL_FALL, 4'b1111, 4'b0000, "rel2_fall_end");
    expect_at(11, SEL_ANY,  4'b0001, 4'b0000, "rel2_any_end");
    step(15);

    // 7-cycle glitch is rejected entirely.
    din[2] = 1'b1;
    expect_quiet(1, 20, 4'b0011, "gl7");
    expect_at(20, SEL_HOLD, 4'b1111, 4'b0011, "gl7_hold");
    step(7);
    din[2] = 1'b0;
    step(13);

    // 8-cycle pulse is accepted and then falls 8 edges after the sync'd fall.
    din[2] = 1'b1;
    expect_quiet(1, 9, 4'b0011, "gl8_pre");
    expect_at(10, SEL_DOUT, 4'b1111, 4'b0111, "gl8_dout_up");
    expect_at(10, SEL_RISE, 4'b1111, 4'b0100, "gl8_rise");
    expect_at(10, SEL_ANY,  4'b0001, 4'b0001, "gl8_any_up");
    expect_at(11, SEL_RISE, 4'b1111, 4'b0000, "gl8_rise_end");
    expect_at(17, SEL_DOUT, 4'b1111, 4'b0111, "gl8_dout_hi");
    expect_at(17, SEL_FALL, 4'b1111, 4'b0000, "gl8_fall_pre");
    expect_at(18, SEL_DOUT, 4'b1111, 4'b0011, "gl8_dout_dn");
    expect_at(18, SEL_FALL, 4'b1111, 4'b0100, "gl8_fall");
    expect_at(18, SEL_ANY,  4'b0001, 4'b0001, "gl8_any_dn");
    expect_at(18, SEL_HOLD, 4'b1111, 4'b0011, "gl8_hold");
    expect_at(19, SEL_FALL, 4'b1111, 4'b0000, "gl8_fall_end");
    expect_at(19, SEL_ANY,  4'b0001, 4'b0000, "gl8_any_end");
    step(8);
    din[2] = 1'b0;
    step(15);

    // Bypass channel follows din 3 edges later with alternating pulses.
    v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v = ~v;
      din[3] = v;
      expect_at(2, SEL_DOUT, 4'b1000, {~v, 3'b000}, "byp_dout_pre");
      expect_at(2, SEL_RISE, 4'b1111, 4'b0000, "byp_rise_pre");
      expect_at(2, SEL_FALL, 4'b1111, 4'b0000, "byp_fall_pre");
      expect_at(2, SEL_ANY,  4'b0001, 4'b0000, "byp_any_pre");
      expect_at(3, SEL_DOUT, 4'b1000, {v, 3'b000}, "byp_dout");
      expect_at(3, SEL_RISE, 4'b1111, {v, 3'b000}, "byp_rise");
      expect_at(3, SEL_FALL, 4'b1111, {~v, 3'b000}, "byp_fall");
      expect_at(3, SEL_ANY,  4'b0001, 4'b0001, "byp_any");
      expect_at(4, SEL_RISE, 4'b1111, 4'b0000, "byp_rise_end");
      expect_at(4, SEL_FALL, 4'b1111, 4'b0000, "byp_fall_end");
      step(4);
    end
    step(6);

    // Reset pulse during a debounce count suppresses the pending rise.
    din[2] = 1'b1;
    expect_quiet(1, 5, 4'b0011, "mid_pre");
    step(5);
    reset_n = 1'b0;
    #1;
    check("mid_rst_dout", dout, 4'b0011);
    check("mid_rst_rise", rise, 4'b0000);
    check("mid_rst_fall", fall, 4'b0000);
    check("mid_rst_hold", hold, 4'b0000);
    check("mid_rst_any",  {3'b000, any_edge}, 4'b0000);
    step(1);
    reset_n = 1'b1;
    expect_quiet(1, 9, 4'b0011, "mid_post");
    expect_at(10, SEL_DOUT, 4'b1111, 4'b0111, "mid_dout");
    expect_at(10, SEL_RISE, 4'b1111, 4'b0100, "mid_rise");
    expect_at(10, SEL_ANY,  4'b0001, 4'b0001, "mid_any");
    expect_at(11, SEL_RISE, 4'b1111, 4'b0000, "mid_rise_end");
    expect_at(19, SEL_HOLD, 4'b1111, 4'b0000, "mid_hold_early");
    expect_at(20, SEL_HOLD, 4'b1111, 4'b0011, "mid_hold01");
    expect_at(29, SEL_HOLD, 4'b1111, 4'b0011, "mid_hold2_early");
    expect_at(30, SEL_HOLD, 4'b1111, 4'b0111, "mid_hold2");
    step(35);

    guard = 0;
    while (sb.size() > 0 && guard < 300) begin
      step(1);
      guard++;
    end
    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
